// File: rtl/data_sync_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_sync_capture_pkg
// Description : Shared CDC constants and state type for data_sync_capture.
// Revision    : 1.0 - initial release
// ============================================================================
package data_sync_capture_pkg;

    localparam int EDGE_RISE         = 0;
    localparam int EDGE_TOGGLE       = 1;
    localparam int DEFAULT_BUS_WIDTH = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } cap_state_t;

endpackage : data_sync_capture_pkg
`default_nettype wire

// File: rtl/data_sync_capture_sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_detect
// Description : Qualifying-edge detector on a synchronized enable, with a
//               priming cycle after reset so a high enable is not an edge.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_detect
    import data_sync_capture_pkg::*;
#(
    parameter int EDGE_MODE = EDGE_RISE
) (
    input  logic clk,
    input  logic RST,
    input  logic i_en,
    output logic o_edge
);

    logic r_en_prev;
    logic r_primed;
    logic w_raw_edge;

    always_ff @(posedge clk) begin
        if (RST) begin
            r_en_prev <= 1'b0;
            r_primed  <= 1'b0;
        end else begin
            r_en_prev <= i_en;
            r_primed  <= 1'b1;
        end
    end

    generate
        if (EDGE_MODE == EDGE_TOGGLE) begin : g_toggle
            assign w_raw_edge = i_en ^ r_en_prev;
        end else begin : g_rise
            assign w_raw_edge = i_en & ~r_en_prev;
        end
    endgenerate

    // Until the first post-reset sample is taken, en_prev is meaningless.
    assign o_edge = r_primed & w_raw_edge;

endmodule : sync_edge_detect
`default_nettype wire

// File: rtl/data_sync_capture.sv
`default_nettype none
// ============================================================================
// Module      : data_sync_capture
// Description : Captures a quasi-static bus on a synchronized enable edge and
//               presents it with a strobe, valid/ready hold and overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module data_sync_capture
    import data_sync_capture_pkg::*;
#(
    parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH,
    parameter int EDGE_MODE = EDGE_RISE
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 SYNC_EN,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 OUT_READY,
    input  logic                 OVERRUN_CLR,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 ENABLE_PULSE,
    output logic                 OUT_VALID,
    output logic                 OVERRUN
);

    cap_state_t           r_state;
    cap_state_t           w_next_state;
    logic [BUS_WIDTH-1:0] r_sync_bus;
    logic                 r_pulse;
    logic                 r_overrun;
    logic                 w_edge;
    logic                 w_capture;
    logic                 w_ovr_set;

    sync_edge_detect #(
        .EDGE_MODE (EDGE_MODE)
    ) u_edge (
        .clk    (clk),
        .RST    (RST),
        .i_en   (SYNC_EN),
        .o_edge (w_edge)
    );

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_ovr_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_edge) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (OUT_READY) begin
                    // Consumer frees the slot this cycle, so a coincident edge reloads it.
                    w_capture    = w_edge;
                    w_next_state = w_edge ? ST_HOLD : ST_IDLE;
                end else if (w_edge) begin
                    w_ovr_set = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_sync_bus <= '0;
            r_pulse    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_pulse <= w_capture;
            if (w_capture) begin
                r_sync_bus <= UNSYNC_BUS;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (OVERRUN_CLR) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign SYNC_BUS     = r_sync_bus;
    assign ENABLE_PULSE = r_pulse;
    assign OUT_VALID    = (r_state == ST_HOLD);
    assign OVERRUN      = r_overrun;

endmodule : data_sync_capture
`default_nettype wire

// File: tb/tb_data_sync_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_sync_capture
// Description : Scoreboard bench for data_sync_capture, rise and toggle modes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sync_capture;

    logic       clk = 1'b0;
    logic       RST;
    logic       en0, rdy0, clr0;
    logic [7:0] bus0;
    logic [7:0] sbus0;
    logic       pls0, vld0, ovr0;
    logic       en1, rdy1, clr1;
    logic [7:0] bus1;
    logic [7:0] sbus1;
    logic       pls1, vld1, ovr1;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    data_sync_capture #(.BUS_WIDTH(8), .EDGE_MODE(0)) dut0 (
        .clk(clk), .RST(RST), .SYNC_EN(en0), .UNSYNC_BUS(bus0),
        .OUT_READY(rdy0), .OVERRUN_CLR(clr0), .SYNC_BUS(sbus0),
        .ENABLE_PULSE(pls0), .OUT_VALID(vld0), .OVERRUN(ovr0)
    );

    data_sync_capture #(.BUS_WIDTH(8), .EDGE_MODE(1)) dut1 (
        .clk(clk), .RST(RST), .SYNC_EN(en1), .UNSYNC_BUS(bus1),
        .OUT_READY(rdy1), .OVERRUN_CLR(clr1), .SYNC_BUS(sbus1),
        .ENABLE_PULSE(pls1), .OUT_VALID(vld1), .OVERRUN(ovr1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every strobe must match the next expected capture for that instance.
    always @(negedge clk) begin
        if (pls0 === 1'b1) begin
            if (q0.size() == 0) chk("dut0 unexpected pulse", 32'(sbus0), 32'hDEAD);
            else                chk("dut0 capture", 32'(sbus0), 32'(q0.pop_front()));
        end
        if (pls1 === 1'b1) begin
            if (q1.size() == 0) chk("dut1 unexpected pulse", 32'(sbus1), 32'hDEAD);
            else                chk("dut1 capture", 32'(sbus1), 32'(q1.pop_front()));
        end
    end

    initial begin
        RST = 1'b1;
        en0 = 1'b1; bus0 = 8'h00; rdy0 = 1'b0; clr0 = 1'b0;
        en1 = 1'b0; bus1 = 8'h00; rdy1 = 1'b0; clr1 = 1'b0;
        tick(); tick();
        chk("rst bus", 32'(sbus0), 32'h0);
        chk("rst pulse", 32'(pls0), 32'h0);
        chk("rst valid", 32'(vld0), 32'h0);
        chk("rst overrun", 32'(ovr0), 32'h0);

        // SYNC_EN high out of reset must not look like an edge.
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("prime valid", 32'(vld0), 32'h0);
            chk("prime pulse", 32'(pls0), 32'h0);
        end

        en0 = 1'b0; tick();
        bus0 = 8'hA5; en0 = 1'b1; q0.push_back(8'hA5); tick();
        chk("k pulse", 32'(pls0), 32'h1);
        chk("k valid", 32'(vld0), 32'h1);
        chk("k bus", 32'(sbus0), 32'hA5);
        tick();
        chk("k+1 pulse", 32'(pls0), 32'h0);
        chk("k+1 valid", 32'(vld0), 32'h1);
        tick();
        rdy0 = 1'b1; tick();
        chk("k+3 valid", 32'(vld0), 32'h0);
        rdy0 = 1'b0;

        en0 = 1'b0; tick();
        en0 = 1'b1; q0.push_back(8'hA5); tick();
        en0 = 1'b0; tick();
        bus0 = 8'h3C; en0 = 1'b1; tick();
        chk("ovr set", 32'(ovr0), 32'h1);
        chk("ovr bus kept", 32'(sbus0), 32'hA5);
        chk("ovr no pulse", 32'(pls0), 32'h0);
        chk("ovr valid", 32'(vld0), 32'h1);
        en0 = 1'b0; clr0 = 1'b1; tick();
        clr0 = 1'b0;
        chk("ovr clr", 32'(ovr0), 32'h0);

        bus0 = 8'h5A; en0 = 1'b1; rdy0 = 1'b1; q0.push_back(8'h5A); tick();
        chk("recap bus", 32'(sbus0), 32'h5A);
        chk("recap pulse", 32'(pls0), 32'h1);
        chk("recap valid", 32'(vld0), 32'h1);
        chk("recap ovr", 32'(ovr0), 32'h0);
        rdy0 = 1'b0; en0 = 1'b0; tick();

        bus0 = 8'h99; en0 = 1'b1; clr0 = 1'b1; tick();
        clr0 = 1'b0;
        chk("set wins ovr", 32'(ovr0), 32'h1);
        chk("set wins bus", 32'(sbus0), 32'h5A);

        RST = 1'b1; tick();
        chk("midhold rst bus", 32'(sbus0), 32'h0);
        chk("midhold rst valid", 32'(vld0), 32'h0);
        chk("midhold rst ovr", 32'(ovr0), 32'h0);
        chk("midhold rst pulse", 32'(pls0), 32'h0);
        RST = 1'b0; tick(); tick();
        chk("post rst valid", 32'(vld0), 32'h0);

        bus1 = 8'h11; en1 = 1'b1; q1.push_back(8'h11); tick();
        chk("tog1 valid", 32'(vld1), 32'h1);
        chk("tog1 bus", 32'(sbus1), 32'h11);
        rdy1 = 1'b1; tick();
        chk("tog1 accept", 32'(vld1), 32'h0);
        rdy1 = 1'b0;
        bus1 = 8'h22; en1 = 1'b0; q1.push_back(8'h22); tick();
        chk("tog2 bus", 32'(sbus1), 32'h22);
        chk("tog2 pulse", 32'(pls1), 32'h1);
        rdy1 = 1'b1; bus1 = 8'h33; en1 = 1'b1; q1.push_back(8'h33); tick();
        bus1 = 8'h44; en1 = 1'b0; q1.push_back(8'h44); tick();
        chk("back2back pulse", 32'(pls1), 32'h1);
        chk("back2back bus", 32'(sbus1), 32'h44);
        tick();
        chk("tog idle valid", 32'(vld1), 32'h0);
        chk("tog idle pulse", 32'(pls1), 32'h0);
        chk("tog ovr", 32'(ovr1), 32'h0);
        rdy1 = 1'b0;

        tick();
        chk("dut0 queue drained", 32'(q0.size()), 32'h0);
        chk("dut1 queue drained", 32'(q1.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_data_sync_capture
`default_nettype wire
